// File: rtl/nasti_pkg.sv
// Shared NASTI definitions.
// Holds the stream-writer FSM state type and the NASTI burst-type and
// write-response encodings used by both the design and its bench.
package nasti_pkg;

  // Write engine states: wait for a request, issue AW, stream W beats,
  // then wait for the B response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } writer_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/nasti_if.sv
// NASTI channel bundles.
// nasti_stream_channel: AXI-stream style source (t_valid/t_ready/t_data/t_last).
// nasti_channel: memory-mapped channel with AW, W, B and a minimal AR/R pair
// (only the handshake bits, since writers tie the read side off).
interface nasti_stream_channel #(
  parameter int N_DATA = 64
) ();
  logic              t_valid;
  logic              t_ready;
  logic [N_DATA-1:0] t_data;
  logic              t_last;

  modport master (output t_valid, t_data, t_last, input t_ready);
  modport slave  (input t_valid, t_data, t_last, output t_ready);
endinterface

interface nasti_channel #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) ();
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;

  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic                    ar_valid;
  logic                    ar_ready;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_valid,
    input  ar_ready,
    input  r_valid,
    output r_ready
  );
endinterface

// File: rtl/nasti_stream_writer.sv
// nasti_stream_writer
// Writes an incoming data stream to memory as a sequence of INCR bursts of
// at most MAX_BURST_LENGTH beats, one burst in flight at a time.
// Ports:
//   aclk, aresetn  clock and asynchronous active-low reset
//   src            stream source (slave side), passed straight through to W
//   dest           NASTI master: drives AW, W, b_ready; read side tied off
//   w_dst, w_len   request byte address / byte length (beat aligned)
//   w_valid        request valid; accepted while w_ready is high
//   w_ready        high when idle
//   w_err          sticky error for the current/last request
module nasti_stream_writer
  import nasti_pkg::*;
#(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int MAX_BURST_LENGTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  nasti_stream_channel.slave    src,
  nasti_channel.master          dest,
  input  logic [ADDR_WIDTH-1:0] w_dst,
  input  logic [ADDR_WIDTH-1:0] w_len,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic                  w_err
);

  localparam int DATA_BYTE_CNT = DATA_WIDTH / 8;
  localparam int SHIFT         = $clog2(DATA_BYTE_CNT);
  localparam int BEAT_W        = $clog2(MAX_BURST_LENGTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << SHIFT) - 1);

  writer_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   remaining_q;
  logic [BEAT_W-1:0]       beat_cnt_q;
  logic [BEAT_W-1:0]       burst_beats_q;
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   remaining_beats;
  logic [BEAT_W-1:0]       next_beats;
  logic [ADDR_WIDTH-1:0]   burst_bytes;
  logic                    aw_fire;
  logic                    w_fire;
  logic                    b_fire;
  logic                    last_beat;
  logic                    req_final;

  // Size of the next burst, derived from what is left of the request.
  // remaining_q only changes on the AW handshake, so aw_len stays stable
  // while aw_valid is held.
  assign remaining_beats = remaining_q >> SHIFT;
  assign next_beats  = (remaining_beats > ADDR_WIDTH'(MAX_BURST_LENGTH))
                     ? BEAT_W'(MAX_BURST_LENGTH)
                     : remaining_beats[BEAT_W-1:0];
  assign burst_bytes = ADDR_WIDTH'(next_beats) << SHIFT;

  assign aw_fire   = (state_q == ADDR) && (remaining_q != '0) && dest.aw_ready;
  assign w_fire    = (state_q == DATA) && src.t_valid && dest.w_ready;
  assign b_fire    = (state_q == RESP) && dest.b_valid;
  assign last_beat = (beat_cnt_q == burst_beats_q - BEAT_W'(1));
  // remaining_q was already reduced at the AW handshake, so zero here means
  // this burst carries the tail of the request.
  assign req_final = last_beat && (remaining_q == '0);

  // Fixed AXI attributes and the unused read side.
  assign dest.aw_id    = '0;
  assign dest.aw_size  = 3'(SHIFT);
  assign dest.aw_burst = BURST_INCR;
  assign dest.aw_cache = '0;
  assign dest.aw_prot  = '0;
  assign dest.aw_lock  = 1'b0;
  assign dest.w_strb   = '1;
  assign dest.ar_valid = 1'b0;
  assign dest.r_ready  = 1'b0;
  assign w_err         = err_q;

  // Next-state and handshake outputs. W is a pure combinational
  // pass-through of the stream so nothing is ever buffered here.
  always_comb begin
    state_d      = state_q;
    w_ready      = 1'b0;
    dest.aw_valid = 1'b0;
    dest.aw_addr  = addr_q;
    dest.aw_len   = 8'(next_beats - BEAT_W'(1));
    dest.w_valid  = 1'b0;
    dest.w_data   = src.t_data;
    dest.w_last   = 1'b0;
    dest.b_ready  = 1'b0;
    src.t_ready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        w_ready = 1'b1;
        if (w_valid) state_d = ADDR;
      end
      ADDR: begin
        // A zero-length request finishes here without touching the bus.
        if (remaining_q == '0) begin
          state_d = IDLE;
        end else begin
          dest.aw_valid = 1'b1;
          if (dest.aw_ready) state_d = DATA;
        end
      end
      DATA: begin
        dest.w_valid = src.t_valid;
        dest.w_last  = last_beat;
        src.t_ready  = dest.w_ready;
        if (w_fire && last_beat) state_d = RESP;
      end
      RESP: begin
        dest.b_ready = 1'b1;
        if (dest.b_valid) state_d = (remaining_q != '0) ? ADDR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, address/length bookkeeping, beat counter and sticky error.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      beat_cnt_q    <= '0;
      burst_beats_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && w_valid) begin
        addr_q      <= w_dst & ~ALIGN_MASK;
        remaining_q <= w_len & ~ALIGN_MASK;
        err_q       <= 1'b0;
      end
      if (aw_fire) begin
        burst_beats_q <= next_beats;
        beat_cnt_q    <= '0;
        addr_q        <= addr_q + burst_bytes;
        remaining_q   <= remaining_q - burst_bytes;
      end
      if (w_fire) begin
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
        // t_last must line up exactly with the end of the request.
        if (src.t_last != req_final) err_q <= 1'b1;
      end
      if (b_fire && dest.b_resp != RESP_OKAY) err_q <= 1'b1;
    end
  end

  // Requests are expected to be beat aligned; the low bits are dropped.
  assert property (@(posedge aclk) disable iff (!aresetn)
                   (w_valid && w_ready) |-> (((w_dst | w_len) & ALIGN_MASK) == '0))
    else $error("nasti_stream_writer: unaligned request");

endmodule

// File: tb/tb_nasti_stream_writer.sv
// Testbench for nasti_stream_writer.
// A reference model plans each request as a list of (address, beats) bursts
// and tracks the data stream, responses and expected error flag; a randomized
// memory slave and stream source drive the DUT cycle by cycle.
module tb_nasti_stream_writer;
  import nasti_pkg::*;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int MAXB  = 8;
  localparam int BYTES = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] w_dst;
  logic [AW-1:0] w_len;
  logic          w_valid;
  logic          w_ready;
  logic          w_err;

  int checkCount = 0;
  int passCount  = 0;

  nasti_stream_channel #(.N_DATA(DW)) src_if ();
  nasti_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dest_if ();

  nasti_stream_writer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_BURST_LENGTH(MAXB)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .src(src_if),
    .dest(dest_if),
    .w_dst(w_dst),
    .w_len(w_len),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_err(w_err)
  );

  // 10-unit clock; the bench drives on the falling edge and samples 1 later.
  always #5 aclk = ~aclk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Runs one request against the model. tlastBeat is the stream beat carrying
  // t_last (-1 for none), errBurst the burst answered with SLVERR (-1 for
  // none), gapPct/bpPct the idle and backpressure percentages, abortBeat the
  // number of written beats after which control returns mid-transfer.
  task automatic applyStimulus(input logic [63:0] dst, input logic [63:0] len,
                               input int tlastBeat, input int errBurst,
                               input int gapPct, input int bpPct, input int abortBeat);
    logic [63:0] expAddr[$];
    int          expBeats[$];
    logic [63:0] data[$];
    logic [63:0] a;
    int          nBeats, nBursts, left, b;
    int          burstIdx, wIdx, beatInBurst, bDelay, cyc;
    logic        awOpen, respWait, done, inData, expErr, expLast;

    nBeats = int'(len >> 3);
    a = dst;
    left = nBeats;
    while (left > 0) begin
      b = (left < MAXB) ? left : MAXB;
      expAddr.push_back(a);
      expBeats.push_back(b);
      a = a + 64'(b * BYTES);
      left = left - b;
    end
    nBursts = expAddr.size();
    for (int i = 0; i < nBeats; i++) data.push_back({$urandom, $urandom});
    expErr = ((nBeats > 0) && (tlastBeat != nBeats - 1)) ||
             ((errBurst >= 0) && (errBurst < nBursts));

    @(negedge aclk);
    w_dst = dst;
    w_len = len;
    w_valid = 1'b1;
    #1 checkOutput("req_ready", w_ready, 1);
    @(negedge aclk);
    w_valid = 1'b0;
    #1 checkOutput("ready_drop", w_ready, 0);
    checkOutput("err_clear", w_err, 0);

    if (nBeats == 0) begin
      checkOutput("zero_no_aw", dest_if.aw_valid, 0);
      @(negedge aclk);
      #1 checkOutput("zero_ready", w_ready, 1);
      checkOutput("zero_no_aw2", dest_if.aw_valid, 0);
      checkOutput("zero_err", w_err, 0);
      return;
    end

    burstIdx = 0; wIdx = 0; beatInBurst = 0; bDelay = 0; cyc = 0;
    awOpen = 1'b0; respWait = 1'b0; done = 1'b0;
    while (!done) begin
      if (cyc > 0) @(negedge aclk);
      if (abortBeat >= 0 && wIdx == abortBeat) return;
      if (cyc > 3000) begin
        checkOutput("timeout", 1, 0);
        return;
      end
      src_if.t_valid   = (wIdx < nBeats) && ($urandom_range(99) >= gapPct);
      src_if.t_data    = (wIdx < nBeats) ? data[wIdx] : 64'h0;
      src_if.t_last    = (wIdx == tlastBeat);
      dest_if.aw_ready = ($urandom_range(99) >= 40);
      dest_if.w_ready  = ($urandom_range(99) >= bpPct);
      dest_if.b_valid  = respWait && (bDelay == 0);
      dest_if.b_resp   = (burstIdx - 1 == errBurst) ? RESP_SLVERR : RESP_OKAY;
      #1;
      inData = awOpen;
      checkOutput("busy", w_ready, 0);
      checkOutput("t_ready", src_if.t_ready, inData ? dest_if.w_ready : 1'b0);
      checkOutput("w_valid", dest_if.w_valid, inData && src_if.t_valid);
      checkOutput("b_ready", dest_if.b_ready, respWait);
      checkOutput("aw_valid", dest_if.aw_valid, !awOpen && !respWait && (burstIdx < nBursts));
      if (!awOpen && !respWait && burstIdx < nBursts) begin
        checkOutput("aw_addr", dest_if.aw_addr, expAddr[burstIdx]);
        checkOutput("aw_len", dest_if.aw_len, 64'(expBeats[burstIdx] - 1));
      end

      if (respWait) begin
        if (dest_if.b_valid) begin
          respWait = 1'b0;
          if (burstIdx == nBursts) done = 1'b1;
        end else if (bDelay > 0) begin
          bDelay--;
        end
      end
      if (inData && dest_if.w_valid && dest_if.w_ready) begin
        expLast = (beatInBurst == expBeats[burstIdx-1] - 1);
        checkOutput("w_data", dest_if.w_data, data[wIdx]);
        checkOutput("w_last", dest_if.w_last, expLast);
        beatInBurst++;
        wIdx++;
        if (expLast) begin
          awOpen = 1'b0;
          respWait = 1'b1;
          bDelay = $urandom_range(2);
        end
      end
      if (dest_if.aw_valid && dest_if.aw_ready && !awOpen && !respWait) begin
        awOpen = 1'b1;
        beatInBurst = 0;
        burstIdx++;
      end
      cyc++;
    end

    @(negedge aclk);
    src_if.t_valid  = 1'b0;
    dest_if.b_valid = 1'b0;
    #1 checkOutput("ready_after_b", w_ready, 1);
    checkOutput("beats_written", 64'(wIdx), 64'(nBeats));
    checkOutput("w_err", w_err, expErr);
  endtask

  initial begin
    int nb, tl;
    logic [63:0] rdst;

    w_valid = 1'b0; w_dst = '0; w_len = '0;
    src_if.t_valid = 1'b0; src_if.t_data = '0; src_if.t_last = 1'b0;
    dest_if.aw_ready = 1'b0; dest_if.w_ready = 1'b0;
    dest_if.b_valid = 1'b0; dest_if.b_resp = RESP_OKAY;
    dest_if.ar_ready = 1'b0; dest_if.r_valid = 1'b0;

    #1;
    checkOutput("rst_w_ready", w_ready, 1);
    checkOutput("rst_aw_valid", dest_if.aw_valid, 0);
    checkOutput("rst_w_valid", dest_if.w_valid, 0);
    checkOutput("rst_b_ready", dest_if.b_ready, 0);
    checkOutput("rst_t_ready", src_if.t_ready, 0);
    checkOutput("rst_w_err", w_err, 0);
    checkOutput("aw_size", dest_if.aw_size, 3);
    checkOutput("aw_burst", dest_if.aw_burst, BURST_INCR);
    checkOutput("aw_id", dest_if.aw_id, 0);
    checkOutput("aw_cache", dest_if.aw_cache, 0);
    checkOutput("aw_prot", dest_if.aw_prot, 0);
    checkOutput("aw_lock", dest_if.aw_lock, 0);
    checkOutput("w_strb", dest_if.w_strb, 8'hff);
    checkOutput("ar_valid", dest_if.ar_valid, 0);
    checkOutput("r_ready", dest_if.r_ready, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;

    applyStimulus(64'h1000, 64'h40, 7, -1, 0, 0, -1);
    applyStimulus(64'h1000, 64'h58, 10, -1, 30, 30, -1);
    applyStimulus(64'h3000, 64'h0, -1, -1, 0, 0, -1);
    applyStimulus(64'h4000, 64'h40, 7, -1, 40, 40, -1);
    applyStimulus(64'h5000, 64'h40, 2, -1, 20, 20, -1);
    applyStimulus(64'h5100, 64'h40, 7, -1, 20, 20, -1);
    applyStimulus(64'h6000, 64'h80, 15, 0, 20, 20, -1);

    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(0, 24);
      rdst = {32'h0, $urandom} & ~64'h7;
      tl = ($urandom_range(3) == 0) ? $urandom_range(0, 23) : nb - 1;
      applyStimulus(rdst, 64'(nb * BYTES), tl, $urandom_range(0, 5) - 2, 25, 25, -1);
    end

    // Abandon a transfer mid-DATA with an error already flagged.
    applyStimulus(64'h2000, 64'h40, 0, -1, 0, 0, 4);
    src_if.t_valid = 1'b1;
    dest_if.w_ready = 1'b1;
    #1;
    checkOutput("pre_rst_w_valid", dest_if.w_valid, 1);
    checkOutput("pre_rst_w_err", w_err, 1);
    #1 aresetn = 1'b0;
    #1;
    checkOutput("arst_w_ready", w_ready, 1);
    checkOutput("arst_aw_valid", dest_if.aw_valid, 0);
    checkOutput("arst_w_valid", dest_if.w_valid, 0);
    checkOutput("arst_b_ready", dest_if.b_ready, 0);
    checkOutput("arst_t_ready", src_if.t_ready, 0);
    checkOutput("arst_w_err", w_err, 0);
    @(negedge aclk);
    src_if.t_valid = 1'b0;
    aresetn = 1'b1;

    applyStimulus(64'h7000, 64'h48, 8, -1, 10, 10, -1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
